tribus_arbiter: RTL and testbench

Round-robin arbiter and driver controller for a shared tri-state data bus with N masters. It grants the bus to one requester at a time and generates the per-master output enables. It also contains the bufif1 driver per master per bit, so at most one master ever drives the bus. A mandatory idle turnaround cycle separates consecutive owners so that enables never overlap. The block sits directly upstream of the bus, and its `oe` vector is the enable that feeds each tri-state buffer.

---
 rtl/tribus_arbiter.sv | 134 +++++++++++++
 tb/tb_tribus_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin owner selection for a shared tri-state bus.
// One master at a time drives the bus through its own bufif1 bank. Every
// drive period is followed by a single idle turnaround cycle, so the enables
// of two successive owners (or two grants to the same owner) never overlap.
module tribus_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    oe,
  inout  wire  [DW-1:0]   bus,
  output logic            bus_valid,
  output logic [2:0]      owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [2:0] OWNER_RST = 3'(N - 1);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t         r_state;
  logic [N-1:0]   r_gnt;
  logic           r_bus_valid;
  logic [2:0]     r_owner;
  logic [3:0]     r_hold;

  state_t         w_nxt_state;
  logic [N-1:0]   w_nxt_gnt;
  logic [2:0]     w_nxt_owner;
  logic [3:0]     w_nxt_hold;

  logic [N-1:0]   w_req_clean;
  logic           w_found;
  logic [2:0]     w_winner;
  logic           w_own_req;

  // Squash unknown request bits to 0 so they can never win arbitration.
  always_comb begin
    w_req_clean = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) w_req_clean[i] = 1'b1;
    end
  end

  // Round-robin search starting one past the current owner, wrapping at N.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && w_req_clean[i] && (i == ((int'(r_owner) + k) % N))) begin
          w_found  = 1'b1;
          w_winner = 3'(i);
        end
      end
    end
  end

  // In DRIVE the grant is one-hot on the owner, so this is req[owner].
  assign w_own_req = |(w_req_clean & r_gnt);

  // Next-state and next-output logic; grants only ever start from IDLE/TURN.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_owner = r_owner;
    w_nxt_hold  = r_hold;
    case (r_state)
      S_IDLE, S_TURN: begin
        if (w_found) begin
          w_nxt_state = S_DRIVE;
          w_nxt_gnt   = ONE_HOT0 << w_winner;
          w_nxt_owner = w_winner;
          w_nxt_hold  = '0;
        end else begin
          w_nxt_state = S_IDLE;
          w_nxt_gnt   = '0;
        end
      end
      S_DRIVE: begin
        if (w_own_req && (r_hold < HOLD_LAST)) begin
          w_nxt_hold = r_hold + 4'd1;
        end else begin
          w_nxt_state = S_TURN;
          w_nxt_gnt   = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_gnt   = '0;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_bus_valid <= 1'b0;
      r_owner     <= OWNER_RST;
      r_hold      <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_gnt       <= w_nxt_gnt;
      r_bus_valid <= |w_nxt_gnt;
      r_owner     <= w_nxt_owner;
      r_hold      <= w_nxt_hold;
    end
  end

  assign gnt       = r_gnt;
  assign oe        = r_gnt;
  assign bus_valid = r_bus_valid;
  assign owner     = r_owner;

  // One tri-state driver per master per bit; only the enabled bank drives.
  for (genvar gi = 0; gi < N; gi++) begin : g_master
    for (genvar gb = 0; gb < DW; gb++) begin : g_bit
      bufif1 u_drv (bus[gb], wdata[gi*DW + gb], oe[gi]);
    end
  end

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed testbench for tribus_arbiter (N=4, DW=8, MAX_HOLD=4).
module tb_tribus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    oe;
  wire  [DW-1:0]   bus;
  logic            bus_valid;
  logic [2:0]      owner;

  int n_checks = 0;
  int n_errors = 0;

  tribus_arbiter #(.N(N), .DW(DW), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .gnt       (gnt),
    .oe        (oe),
    .bus       (bus),
    .bus_valid (bus_valid),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] onehot_ok(input logic [N-1:0] v);
    return ($countones(v) <= 1) ? 32'd1 : 32'd0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_g;
    logic [7:0]   exp_b;
    int s;
    int p;

    wdata = {8'h44, 8'hA5, 8'h22, 8'h11};

    // 1. Reset with all masters requesting
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_oe",    32'(oe), 32'h0);
    chk("rst_valid", 32'(bus_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'd3);
    rst_n = 1'b1;
    tick();
    chk("rel_gnt",   32'(gnt), 32'h1);
    chk("rel_oe",    32'(oe), 32'h1);
    chk("rel_bus",   32'(bus), 32'h11);
    chk("rel_owner", 32'(owner), 32'd0);
    chk("rel_valid", 32'(bus_valid), 32'h1);
    req = 4'b0000;
    tick();
    chk("rel_turn",  32'(gnt), 32'h0);
    tick();
    chk("rel_idle",  32'(gnt), 32'h0);

    // 2. Single request held two edges
    req = 4'b0100;
    tick();
    chk("t2_gnt0", 32'(gnt), 32'h4);
    chk("t2_bus0", 32'(bus), 32'hA5);
    tick();
    chk("t2_gnt1", 32'(gnt), 32'h4);
    chk("t2_bus1", 32'(bus), 32'hA5);
    req = 4'b0000;
    tick();
    chk("t2_turn",  32'(gnt), 32'h0);
    chk("t2_tval",  32'(bus_valid), 32'h0);
    tick();
    chk("t2_idle",  32'(gnt), 32'h0);
    chk("t2_owner", 32'(owner), 32'd2);

    // 3. Hold limit with a single persistent requester
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_g = ((i % 5) != 4) ? 4'b0010 : 4'b0000;
      chk("t3_gnt", 32'(gnt), 32'(exp_g));
      chk("t3_val", 32'(bus_valid), 32'(|exp_g));
      if (exp_g != 0) chk("t3_bus", 32'(bus), 32'h22);
    end
    req = 4'b0000;
    tick();
    chk("t3_idle", 32'(gnt), 32'h0);

    // 4. Full-load rotation starting from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 25; i++) begin
      tick();
      s = i / 5;
      p = i % 5;
      exp_g = (p < 4) ? (4'b0001 << (s % 4)) : 4'b0000;
      chk("t4_gnt",    32'(gnt), 32'(exp_g));
      chk("t4_onehot", onehot_ok(oe), 32'd1);
      chk("t4_oe_gnt", 32'(oe), 32'(exp_g));
      if (p < 4) begin
        exp_b = wdata[(s % 4)*DW +: DW];
        chk("t4_bus", 32'(bus), 32'(exp_b));
      end
    end
    req = 4'b0000;
    tick();
    chk("t4_idle", 32'(gnt), 32'h0);

    // 5. Reset asserted in the second drive cycle of master 1
    req = 4'b0010;
    tick();
    chk("t5_d1", 32'(gnt), 32'h2);
    tick();
    chk("t5_d2", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t5_oe",    32'(oe), 32'h0);
    chk("t5_gnt",   32'(gnt), 32'h0);
    chk("t5_valid", 32'(bus_valid), 32'h0);
    chk("t5_owner", 32'(owner), 32'd3);
    req = 4'b0011;
    tick();
    chk("t5_hold", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t5_win0", 32'(gnt), 32'h1);
    chk("t5_bus",  32'(bus), 32'h11);
    req = 4'b0000;
    tick();
    tick();
    chk("t5_idle", 32'(gnt), 32'h0);

    // 6. Unknown request bits, then a late request during another drive
    req = 4'bx000;
    tick();
    chk("t6_xoe",  32'(oe), 32'h0);
    chk("t6_xgnt", 32'(gnt), 32'h0);
    tick();
    chk("t6_xoe2", 32'(oe), 32'h0);
    req = 4'b0010;
    tick();
    chk("t6_m1", 32'(gnt), 32'h2);
    req = 4'b1010;
    tick();
    chk("t6_nopre", 32'(gnt), 32'h2);
    req = 4'b1000;
    tick();
    chk("t6_turn", 32'(gnt), 32'h0);
    tick();
    chk("t6_m3",    32'(gnt), 32'h8);
    chk("t6_owner", 32'(owner), 32'd3);
    chk("t6_bus",   32'(bus), 32'h44);
    req = 4'b0000;
    tick();
    tick();
    chk("t6_idle", 32'(gnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
